// File: rtl/seq_detect_1011_if.sv
// Bit-stream and status bundle for seq_detect_1011: the master drives Clear/En/D; the detector returns Z/State/Count.
// Combinational bundle only; no latency; no backpressure (En qualifies each bit).
// Count width follows COUNT_WIDTH and must match the detector's parameter.
interface seq_detect_1011_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   Clear;
    logic                   En;
    logic                   D;
    logic                   Z;
    logic [2:0]             State;
    logic [COUNT_WIDTH-1:0] Count;

    modport master (
        output Clear, En, D,
        input  Z, State, Count
    );

    modport slave (
        input  Clear, En, D,
        output Z, State, Count
    );
endinterface

// File: rtl/seq_detect_1011.sv
// Serial 1011 detector with Moore match flag and saturating match counter; SEQ_DETECT_OVERLAP_EN selects overlapping detection.
// Latency: Z/Count update one Clock edge after the sampled bit completing 1011.
// Backpressure: none; En=0 freezes State and Count, D is ignored.
module seq_detect_1011 #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    seq_detect_1011_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_1     = 3'd1,
        S_10    = 3'd2,
        S_101   = 3'd3,
        S_MATCH = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    state_t                 state_adv;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   illegal;
    logic                   enter_match;

    // Next state assuming a valid bit is consumed this edge.
    always_comb begin
        state_adv = S_IDLE;
        illegal   = 1'b0;
        case (state_q)
            S_IDLE:  state_adv = bus.D ? S_1     : S_IDLE;
            S_1:     state_adv = bus.D ? S_1     : S_10;
            S_10:    state_adv = bus.D ? S_101   : S_IDLE;
            S_101:   state_adv = bus.D ? S_MATCH : S_10;
`ifdef SEQ_DETECT_OVERLAP_EN
            S_MATCH: state_adv = bus.D ? S_1     : S_10;
`else
            S_MATCH: state_adv = bus.D ? S_1     : S_IDLE;
`endif
            default: begin
                state_adv = S_IDLE;
                illegal   = 1'b1;
            end
        endcase
    end

    // Clear beats En; an illegal code recovers to idle even with En low.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        enter_match = 1'b0;
        if (bus.Clear) begin
            state_d = S_IDLE;
            count_d = '0;
        end else if (illegal) begin
            state_d = S_IDLE;
        end else if (bus.En) begin
            state_d     = state_adv;
            enter_match = (state_adv == S_MATCH) && (state_q != S_MATCH);
            if (enter_match && (count_q != {COUNT_WIDTH{1'b1}})) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign bus.Z     = (state_q == S_MATCH);
    assign bus.State = state_q;
    assign bus.Count = count_q;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Directed table-driven bench for seq_detect_1011: an 8-bit counter instance plus a 2-bit instance for saturation.
module tb_seq_detect_1011;

    logic Clock = 1'b0;
    logic rst, clr, en, d;

    always #5 Clock = ~Clock;

    seq_detect_1011_if #(.COUNT_WIDTH(8)) bus8 ();
    seq_detect_1011_if #(.COUNT_WIDTH(2)) bus2 ();

    assign bus8.Clear = clr;
    assign bus8.En    = en;
    assign bus8.D     = d;
    assign bus2.Clear = clr;
    assign bus2.En    = en;
    assign bus2.D     = d;

    seq_detect_1011 #(.COUNT_WIDTH(8)) dut8 (.Clock(Clock), .Reset(rst), .bus(bus8));
    seq_detect_1011 #(.COUNT_WIDTH(2)) dut2 (.Clock(Clock), .Reset(rst), .bus(bus2));

    typedef struct {
        logic       rst;
        logic       clr;
        logic       en;
        logic       d;
        logic [2:0] st;
        logic       z;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input int idx, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic e, input logic dd);
        rst = r;
        clr = c;
        en  = e;
        d   = dd;
        @(posedge Clock);
        #1;
    endtask

    logic [2:0] ov_st[7];
    logic [7:0] ov_cnt[7];
    int         exp2;

    initial begin
        rst = 1'b1; clr = 1'b0; en = 1'b0; d = 1'b0;

        // {rst, clr, en, d, state, z, count} -- expected values after the edge
        // reset with D toggling, then a plain 1011
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'd0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 8'd1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0});
        // enable gating, including X on D while En=0, then hold in match
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'bx, 3'd2, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 8'd1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 8'd1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'd1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 8'd0});
        // near miss 1,0,0,1,0,1,0,1,1
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 8'd1});
        // clear on the completing edge
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'd1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 8'd1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 8'd1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 8'd0});
        // reset after 101, then a lone 1
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 8'd0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'd0});
        // reset overrides a simultaneous clear
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 8'd0});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].clr, tbl[i].en, tbl[i].d);
            check("tbl_state", i, 16'(bus8.State), 16'(tbl[i].st));
            check("tbl_z",     i, 16'(bus8.Z),     16'(tbl[i].z));
            check("tbl_count", i, 16'(bus8.Count), 16'(tbl[i].cnt));
        end

        // overlap: 1,0,1,1,0,1,1
`ifdef SEQ_DETECT_OVERLAP_EN
        ov_st  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4};
        ov_cnt = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
`else
        ov_st  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd1};
        ov_cnt = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
`endif
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 1'b1, (i == 1 || i == 4) ? 1'b0 : 1'b1);
            check("ovl_state", i, 16'(bus8.State), 16'(ov_st[i]));
            check("ovl_z",     i, 16'(bus8.Z),     16'(ov_st[i] == 3'd4));
            check("ovl_count", i, 16'(bus8.Count), 16'(ov_cnt[i]));
        end

        // saturation: five non-overlapping 1011 patterns
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b0, 1'b1, 1'b1);
            exp2 = (k + 1 > 3) ? 3 : k + 1;
            check("sat_count2", k, 16'(bus2.Count), 16'(exp2));
            check("sat_z2",     k, 16'(bus2.Z),     16'd1);
            check("sat_count8", k, 16'(bus8.Count), 16'(k + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
